// File: rtl/ifu_pkg.sv
// ifu_pkg: definitions shared by the instruction fetch unit and its users.
//   ifu_state_e      - fetch FSM state encoding
//   NOP_INSN         - instruction word presented with a fetch fault
//   DEFAULT_RESET_PC - PC loaded on reset unless overridden
//   word_aligned()   - true when an address has its two low bits clear
package ifu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP,
        ST_HOLD,
        ST_HALT
    } ifu_state_e;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ifu_if.sv
// ifu_if: signal bundle between the fetch unit, instruction memory and the
// downstream decode stage.
//   imem_req_*   - read request channel (valid/ready, word address)
//   imem_resp_*  - read response (one pulse per accepted request, data, fault)
//   redirect_*   - PC change requested by downstream
//   inst_*       - fetched instruction handoff (valid/ready, pc, word, fault)
// Modports: master = fetch unit side, slave = memory/downstream side.
interface ifu_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_cmd;
    logic        inst_fault;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  imem_resp_err,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst_pc,
        output inst_cmd,
        output inst_fault
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_resp_valid,
        output imem_resp_data,
        output imem_resp_err,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst_pc,
        input  inst_cmd,
        input  inst_fault
    );

endinterface

// File: rtl/ifu.sv
// ifu: instruction fetch unit. Owns the PC, issues one word read per
// instruction (at most one outstanding), presents the fetched word with its
// PC downstream, and follows redirects, discarding stale responses.
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - ifu_if.master: imem request/response, redirect, inst handoff
// Parameter RESET_PC: PC value loaded on reset.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic   clk,
    input  logic   rst,
    ifu_if.master  bus
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] inst_cmd_q, inst_cmd_d;
    logic        inst_fault_q, inst_fault_d;

    logic        req_fire;
    logic        handoff;
    logic        redirect;
    logic        resp;

    // A misaligned PC never reaches memory; it turns into a fault instruction.
    assign bus.imem_req_valid = (state_q == ST_REQ) && word_aligned(pc_q);
    assign bus.imem_req_addr  = pc_q;

    // Redirect wins over the handoff of a held instruction in the same cycle.
    assign bus.inst_valid = (state_q == ST_HOLD) && !bus.redirect_valid;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_cmd   = inst_cmd_q;
    assign bus.inst_fault = inst_fault_q;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign handoff  = bus.inst_valid && bus.inst_ready;
    assign redirect = bus.redirect_valid;
    assign resp     = bus.imem_resp_valid;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_pc_d    = inst_pc_q;
        inst_cmd_d   = inst_cmd_q;
        inst_fault_d = inst_fault_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end

            ST_REQ: begin
                if (!word_aligned(pc_q)) begin
                    inst_pc_d    = pc_q;
                    inst_cmd_d   = NOP_INSN;
                    inst_fault_d = 1'b1;
                    state_d      = ST_HOLD;
                end else if (redirect) begin
                    // Once the request fired, its response is stale and must
                    // be absorbed in DROP before issuing the new one.
                    pc_d    = bus.redirect_pc;
                    state_d = req_fire ? ST_DROP : ST_REQ;
                end else if (req_fire) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = resp ? ST_REQ : ST_DROP;
                end else if (resp) begin
                    inst_pc_d    = pc_q;
                    inst_cmd_d   = bus.imem_resp_data;
                    inst_fault_d = bus.imem_resp_err;
                    state_d      = ST_HOLD;
                end
            end

            ST_DROP: begin
                if (redirect) begin
                    pc_d = bus.redirect_pc;
                end
                if (resp) begin
                    state_d = ST_REQ;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = ST_REQ;
                end else if (handoff) begin
                    if (inst_fault_q) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_REQ;
                    end
                end
            end

            ST_HALT: begin
                if (redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            inst_pc_q    <= '0;
            inst_cmd_q   <= '0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_pc_q    <= inst_pc_d;
            inst_cmd_q   <= inst_cmd_d;
            inst_fault_q <= inst_fault_d;
        end
    end

endmodule
